// File: rtl/rx_reset_seq_pkg.sv
// Shared definitions for the RX channel reset sequencer: state encodings,
// reset hold lengths and the timer width helper.
package rx_reset_seq_pkg;

   typedef enum logic [2:0] {
      TX_WAIT    = 3'd0,
      LOS_WAIT   = 3'd1,
      SERDES_RST = 3'd2,
      CDR_WAIT   = 3'd3,
      PCS_RST    = 3'd4,
      NORMAL     = 3'd5
   } rx_state_e;

   localparam int unsigned SERDES_RST_CYCLES = 32'd8;
   localparam int unsigned PCS_RST_CYCLES    = 32'd4;

   // One shared timer must cover both the lock window and the 8-cycle hold.
   function automatic int unsigned cnt_width(input int unsigned count_index);
      return ((count_index + 32'd1) > 32'd3) ? (count_index + 32'd1) : 32'd3;
   endfunction

endpackage

// File: rtl/rx_reset_seq_sync.sv
// Two-flop synchronizer with a configurable reset level, used for the
// asynchronous CDR loss-of-lock and loss-of-signal indications.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rx_reset_seq.sv
// RX channel reset sequencer: waits for TX, signal and CDR lock before
// releasing the SERDES reset and then the PCS reset.
module rx_reset_seq
   import rx_reset_seq_pkg::*;
#(
   parameter int unsigned COUNT_INDEX = 17
) (
   input  logic       refclkdiv2,
   input  logic       rst_n,
   input  logic       tx_pcs_rst_ch_c,
   input  logic       rx_cdr_lol_ch_s,
   input  logic       rx_los_low_ch_s,
   output logic       rx_serdes_rst_ch_c,
   output logic       rx_pcs_rst_ch_c,
   output logic       rx_ready,
   output logic [3:0] retry_cnt
);

   localparam int unsigned   CW          = cnt_width(COUNT_INDEX);
   localparam logic [CW-1:0] LOCK_LAST   = CW'((64'd1 << COUNT_INDEX) - 64'd1);
   localparam logic [CW-1:0] SERDES_LAST = CW'(SERDES_RST_CYCLES - 32'd1);
   localparam logic [CW-1:0] PCS_LAST    = CW'(PCS_RST_CYCLES - 32'd1);
   localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

   logic          lol_s;
   logic          los_s;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic          retry_inc_s;
   logic          timed_s;
   logic          serdes_rst_q;
   logic          pcs_rst_q;
   logic          ready_q;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync_lol (
      .clk_i  (refclkdiv2),
      .rst_ni (rst_n),
      .d_i    (rx_cdr_lol_ch_s),
      .q_o    (lol_s)
   );

   sync_2ff #(.RESET_VAL(1'b1)) u_sync_los (
      .clk_i  (refclkdiv2),
      .rst_ni (rst_n),
      .d_i    (rx_los_low_ch_s),
      .q_o    (los_s)
   );

   // Next-state, shared timer and retry counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;

      if ((state_q != TX_WAIT) && tx_pcs_rst_ch_c) begin
         state_d = TX_WAIT;
      end else begin
         case (state_q)
            TX_WAIT:    state_d = tx_pcs_rst_ch_c ? TX_WAIT : LOS_WAIT;
            LOS_WAIT:   state_d = los_s ? LOS_WAIT : SERDES_RST;
            SERDES_RST: state_d = (cnt_q == SERDES_LAST) ? CDR_WAIT : SERDES_RST;
            CDR_WAIT: begin
               if (los_s) begin
                  state_d = LOS_WAIT;
               end else if (!lol_s && (cnt_q == LOCK_LAST)) begin
                  state_d = PCS_RST;
               end else begin
                  state_d = CDR_WAIT;
               end
            end
            PCS_RST:    state_d = (cnt_q == PCS_LAST) ? NORMAL : PCS_RST;
            NORMAL: begin
               if (los_s) begin
                  state_d = LOS_WAIT;
               end else if (lol_s) begin
                  state_d = SERDES_RST;
               end else begin
                  state_d = NORMAL;
               end
            end
            default:    state_d = TX_WAIT;
         endcase
      end

      // Lock loss inside the window restarts it; the timer never wraps.
      timed_s = (state_q == SERDES_RST) || (state_q == CDR_WAIT) || (state_q == PCS_RST);
      if (state_d != state_q) begin
         cnt_d = {CW{1'b0}};
      end else if ((state_q == CDR_WAIT) && lol_s) begin
         cnt_d = {CW{1'b0}};
      end else if (timed_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else if (timed_s) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = {CW{1'b0}};
      end

      retry_inc_s = ((state_q == CDR_WAIT) && (state_d == LOS_WAIT)) ||
                    ((state_q == NORMAL) &&
                     ((state_d == LOS_WAIT) || (state_d == SERDES_RST)));
      if (retry_inc_s && (retry_q != 4'd15)) begin
         retry_d = retry_q + 4'd1;
      end else begin
         retry_d = retry_q;
      end
   end

   // State, timer and retry registers.
   always_ff @(posedge refclkdiv2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_WAIT;
         cnt_q   <= {CW{1'b0}};
         retry_q <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
      end
   end

   // Registered channel controls; SERDES is only released once the CDR phase starts.
   always_ff @(posedge refclkdiv2 or negedge rst_n) begin
      if (!rst_n) begin
         serdes_rst_q <= 1'b1;
         pcs_rst_q    <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         serdes_rst_q <= !((state_q == CDR_WAIT) || (state_q == PCS_RST) || (state_q == NORMAL));
         pcs_rst_q    <= (state_q != NORMAL);
         ready_q      <= (state_q == NORMAL);
      end
   end

   assign rx_serdes_rst_ch_c = serdes_rst_q;
   assign rx_pcs_rst_ch_c    = pcs_rst_q;
   assign rx_ready           = ready_q;
   assign retry_cnt          = retry_q;

endmodule

// File: tb/tb_rx_reset_seq.sv
// Self-checking bench for rx_reset_seq with a 16-cycle lock window.
module tb_rx_reset_seq;

   typedef struct {
      logic       tx;
      logic       lol;
      logic       los;
      int         cyc;
      logic       e_serdes;
      logic       e_pcs;
      logic       e_ready;
      logic [3:0] e_retry;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx;
   logic       lol;
   logic       los;
   logic       serdes;
   logic       pcs;
   logic       ready;
   logic [3:0] retry;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[10];
   vec_t exp_q[$];
   vec_t cur;
   int   exp_retry;
   int   bad;

   always #5 clk = ~clk;

   rx_reset_seq #(.COUNT_INDEX(4)) dut (
      .refclkdiv2         (clk),
      .rst_n              (rst_n),
      .tx_pcs_rst_ch_c    (tx),
      .rx_cdr_lol_ch_s    (lol),
      .rx_los_low_ch_s    (los),
      .rx_serdes_rst_ch_c (serdes),
      .rx_pcs_rst_ch_c    (pcs),
      .rx_ready           (ready),
      .retry_cnt          (retry)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic pick(input int sel);
      case (sel)
         0:       return serdes;
         1:       return pcs;
         default: return ready;
      endcase
   endfunction

   // Count clock edges until an output reaches val; sel 0=serdes 1=pcs 2=ready.
   task automatic wait_for(input string nm, input int sel, input logic val, input int exp_edges);
      int  n;
      bit  hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && (n < 200)) begin
         tick(1);
         n++;
         if (pick(sel) === val) hit = 1'b1;
      end
      if (!hit) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout after %0d edges, expected %0d", nm, n, exp_edges);
      end else begin
         check(nm, n, exp_edges);
      end
   endtask

   task automatic bump_retry();
      exp_retry = (exp_retry < 15) ? exp_retry + 1 : 15;
   endtask

   initial begin
      //            tx    lol   los  cyc  serdes pcs  ready retry
      vecs[0] = '{1'b1, 1'b1, 1'b1,  5, 1'b1, 1'b1, 1'b0, 4'd0};
      vecs[1] = '{1'b0, 1'b1, 1'b1,  5, 1'b1, 1'b1, 1'b0, 4'd0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 20, 1'b0, 1'b1, 1'b0, 4'd0};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 30, 1'b0, 1'b0, 1'b1, 4'd0};
      vecs[4] = '{1'b0, 1'b1, 1'b0,  6, 1'b1, 1'b1, 1'b0, 4'd1};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 4'd1};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b1, 4'd2};
      vecs[8] = '{1'b1, 1'b0, 1'b0,  5, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b1, 4'd2};

      rst_n = 1'b0;
      tx    = 1'b1;
      lol   = 1'b1;
      los   = 1'b1;
      tick(3);
      check("reset_serdes", serdes, 1);
      check("reset_pcs", pcs, 1);
      check("reset_ready", ready, 0);
      check("reset_retry", retry, 0);
      rst_n = 1'b1;

      // Steady-state table through the scoreboard queue.
      for (int i = 0; i < 10; i++) begin
         tx  = vecs[i].tx;
         lol = vecs[i].lol;
         los = vecs[i].los;
         exp_q.push_back(vecs[i]);
         tick(vecs[i].cyc);
         cur = exp_q.pop_front();
         check($sformatf("vec%0d_serdes", i), serdes, cur.e_serdes);
         check($sformatf("vec%0d_pcs", i), pcs, cur.e_pcs);
         check($sformatf("vec%0d_ready", i), ready, cur.e_ready);
         check($sformatf("vec%0d_retry", i), retry, cur.e_retry);
      end

      // Bring-up timing from a fresh reset.
      rst_n = 1'b0;
      tx    = 1'b1;
      lol   = 1'b1;
      los   = 1'b1;
      tick(2);
      rst_n = 1'b1;
      exp_retry = 0;
      tick(3);
      tx = 1'b0;
      tick(2);
      los = 1'b0;
      wait_for("bringup_serdes_release", 0, 1'b0, 12);
      check("bringup_pcs_held", pcs, 1);
      tick(5);
      lol = 1'b0;
      wait_for("bringup_pcs_release", 1, 1'b0, 23);
      check("bringup_ready", ready, 1);
      check("bringup_retry", retry, exp_retry);

      // Lock loss in NORMAL, then full relock.
      lol = 1'b1;
      wait_for("normal_lol_ready_drop", 2, 1'b0, 4);
      bump_retry();
      check("normal_lol_serdes", serdes, 1);
      check("normal_lol_retry", retry, exp_retry);
      lol = 1'b0;
      wait_for("normal_lol_serdes_hold", 0, 1'b0, 8);
      wait_for("normal_lol_relock", 2, 1'b1, 20);

      // One-cycle lock glitch after 10 locked cycles restarts the window.
      lol = 1'b1;
      wait_for("glitch_setup_ready_drop", 2, 1'b0, 4);
      bump_retry();
      tick(20);
      check("glitch_cdr_wait_serdes", serdes, 0);
      lol = 1'b0;
      tick(12);
      lol = 1'b1;
      tick(1);
      lol = 1'b0;
      wait_for("glitch_window_restart", 1, 1'b0, 23);
      check("glitch_retry", retry, exp_retry);

      // TX reset while NORMAL.
      tx = 1'b1;
      tick(1);
      check("tx_normal_lag_ready", ready, 1);
      tick(1);
      check("tx_normal_ready", ready, 0);
      check("tx_normal_serdes", serdes, 1);
      check("tx_normal_pcs", pcs, 1);
      check("tx_normal_retry", retry, exp_retry);
      tx = 1'b0;
      wait_for("tx_normal_recover", 2, 1'b1, 31);

      // TX reset while in PCS_RST.
      lol = 1'b1;
      wait_for("tx_pcs_setup_drop", 2, 1'b0, 4);
      bump_retry();
      lol = 1'b0;
      wait_for("tx_pcs_setup_serdes", 0, 1'b0, 8);
      tick(16);
      tx = 1'b1;
      tick(1);
      check("tx_pcs_lag_serdes", serdes, 0);
      check("tx_pcs_lag_pcs", pcs, 1);
      tick(1);
      check("tx_pcs_serdes", serdes, 1);
      check("tx_pcs_pcs", pcs, 1);
      tick(10);
      check("tx_pcs_no_ready", ready, 0);
      check("tx_pcs_retry", retry, exp_retry);
      tx = 1'b0;
      wait_for("tx_pcs_recover", 2, 1'b1, 31);

      // LOS and LOL together in NORMAL: LOS wins.
      los = 1'b1;
      lol = 1'b1;
      wait_for("both_ready_drop", 2, 1'b0, 4);
      bump_retry();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (serdes !== 1'b1) bad++;
      end
      check("both_los_wait_hold", bad, 0);
      check("both_retry", retry, exp_retry);
      los = 1'b0;
      lol = 1'b0;
      wait_for("both_recover", 2, 1'b1, 32);

      // Repeated signal loss saturates the retry counter.
      for (int i = 0; i < 20; i++) begin
         los = 1'b1;
         wait_for("retry_loop_drop", 2, 1'b0, 4);
         bump_retry();
         check("retry_loop_cnt", retry, exp_retry);
         los = 1'b0;
         wait_for("retry_loop_recover", 2, 1'b1, 32);
      end
      check("retry_saturated", retry, 15);

      // Asynchronous reset while in CDR_WAIT.
      lol = 1'b1;
      wait_for("async_setup_drop", 2, 1'b0, 4);
      tick(20);
      check("async_setup_cdr", serdes, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_serdes", serdes, 1);
      check("async_pcs", pcs, 1);
      check("async_ready", ready, 0);
      check("async_retry", retry, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
